pi_request_queue: RTL and testbench
===================================

Name: pi_request_queue

Overview:
- Upstream stage of the 68k bus state machine. Receives Pi GPIO register writes and captures them into staging registers.
- Each write to PI_REG_ADDR_HI commits a complete bus request into a DEPTH-entry FIFO. Writes are posted, so the Pi does not wait for the bus.
- Presents the head request to the bus FSM over a valid/ready handshake.
- Returns read data and a status word to the Pi read mux.

Parameters:
- DEPTH, 4, FIFO entries. Must be a power of 2 and ≥2.
- PTR_W, $clog2(DEPTH), pointer width. Derived; do not override.

Ports:
- SYSCLK  in  1  system clock (PLL output); all logic on posedge.
- RESET  in  1  asynchronous reset, active-high.
- PI_WR  in  1  raw Pi write strobe; active on falling edge.
- PI_RD  in  1  raw Pi read strobe.
- PI_A  in  3  Pi register address (PI_REG_* encodings).
- PI_DATA_IN  in  16  Pi write data.
- PI_DATA_OUT  out  16  Pi read data (combinational mux).
- PI_DATA_OE  out  1  = ~PI_RD & PI_WR (combinational, raw pins).
- REQ_VALID  out  1  FIFO head valid.
- REQ_READY  in  1  bus FSM accepts head.
- REQ_ADDR  out  24  head address.
- REQ_FC  out  3  head function code.
- REQ_SIZE  out  2  head size.
- REQ_READ  out  1  head is read.
- REQ_DATA  out  32  head write data.
- DONE_STROBE  in  1  one-cycle pulse: in-flight request terminated.
- DONE_DATA  in  32  read data, valid with DONE_STROBE.
- BUSY  out  1  queue non-empty OR request in flight (drives GPIO3).
- FULL  out  1  FIFO full.

Behaviour:
- Reset values: FIFO empty; REQ_VALID=0; BUSY=0; FULL=0; staging regs 0; read data 0; pend_reads=0; inflight=0; overflow=0; PI_WR sync flops=1.
- PI_WR sync: two flops (wr_a, wr_b). wr_edge = wr_b & ~wr_a. PI_A and PI_DATA_IN are sampled on the wr_edge cycle; the Pi holds them stable.
- On wr_edge, by PI_A:
  - DATA_LO / DATA_HI → stage_data[15:0] / [31:16].
  - ADDR_LO → stage_addr[15:0].
  - ADDR_HI → commit entry {fc=d[13:11], read=d[10], size=d[9:8], addr={d[7:0], stage_addr[15:0]}, data=stage_data}.
  - STATUS → clear overflow.
  - Other addresses ignored.
- Commit latency: entry visible on REQ_* and REQ_VALID=1 on the cycle after wr_edge (if the FIFO was empty).
- Pop: REQ_VALID & REQ_READY. The read pointer advances on the same edge. REQ_* are registered outputs of the head entry.
- Push when full:
  - Accepted if a pop occurs in the same cycle.
  - Otherwise the entry is dropped, overflow is set (sticky), and the pointers are unchanged.
- Occupancy count is PTR_W+1 bits. Pointers wrap modulo DEPTH. Push+pop in the same cycle leaves the count unchanged.
- In-flight tracking:
  - Pop sets inflight=1 and inflight_read=head.read.
  - DONE_STROBE with inflight=1 clears inflight. If inflight_read, it also latches DONE_DATA into rd_data.
  - DONE_STROBE with inflight=0 is ignored.
  - Pop and DONE in the same cycle: DONE retires the old request; the new one becomes in flight.
- pend_reads counter (PTR_W+2 bits): +1 on accepted read commit, −1 on DONE of an inflight read. Both in the same cycle → unchanged.
- PI_DATA_OUT mux:
  - DATA_LO → rd_data[15:0]; DATA_HI → rd_data[31:16].
  - ADDR_LO → stage_addr[15:0].
  - STATUS → {level[3:0] or 0, 7'd0, overflow, BUSY, pend_reads!=0, empty, FULL}.
  - Others → 0.
- RESET asserted mid-transfer: queue, inflight and pend_reads clear immediately. A later DONE_STROBE is ignored.

Optional Feature:
- Macro PI_QUEUE_LEVEL_STATUS_EN.
- Defined: STATUS[15:12] = occupancy count (saturating at 15).
- Undefined: STATUS[15:12] = 0 and no extra logic.

Test Plan:
- Write DATA_LO=0x5678, DATA_HI=0x1234, ADDR_LO=0xBEEF, ADDR_HI=0x0612 → 1 cycle after ADDR_HI edge: REQ_VALID=1, REQ_ADDR=0x12BEEF, REQ_FC=0, REQ_READ=1, REQ_SIZE=2, REQ_DATA=0x12345678; STATUS bit2=1.
- Read request popped, then DONE_STROBE with DONE_DATA=0xCAFEF00D → DATA_LO reads 0xF00D, DATA_HI reads 0xCAFE; STATUS bit2=0, BUSY=0.
- REQ_READY=0, commit 5 writes with DEPTH=4 → FULL=1, 5th dropped, STATUS bit4=1; Pi write to STATUS → bit4=0; drain yields exactly 4 entries in commit order.
- FULL with REQ_READY=1 on the same cycle as an ADDR_HI commit → entry accepted, count stays 4, no overflow.
- Pop and DONE_STROBE in the same cycle, then assert RESET mid-flight → old read data latched, new inflight=1; after RESET: REQ_VALID=0, BUSY=0, STATUS=0x0002, later DONE ignored.
- With PI_QUEUE_LEVEL_STATUS_EN defined, 3 queued entries → STATUS[15:12]=3; without the macro → 0.

Source files
------------

// File: rtl/pi_request_queue.sv
// pi_request_queue: stages Pi GPIO register writes and posts complete 68k bus requests into a
// DEPTH-entry FIFO. Define PI_QUEUE_LEVEL_STATUS_EN to report FIFO occupancy in STATUS[15:12].
// Pi register map (PI_A): 0 DATA_LO, 1 DATA_HI, 2 ADDR_LO, 3 ADDR_HI, 4 STATUS.
module pi_request_queue #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        SYSCLK,
  input  logic        RESET,
  input  logic        PI_WR,
  input  logic        PI_RD,
  input  logic [2:0]  PI_A,
  input  logic [15:0] PI_DATA_IN,
  output logic [15:0] PI_DATA_OUT,
  output logic        PI_DATA_OE,
  output logic        REQ_VALID,
  input  logic        REQ_READY,
  output logic [23:0] REQ_ADDR,
  output logic [2:0]  REQ_FC,
  output logic [1:0]  REQ_SIZE,
  output logic        REQ_READ,
  output logic [31:0] REQ_DATA,
  input  logic        DONE_STROBE,
  input  logic [31:0] DONE_DATA,
  output logic        BUSY,
  output logic        FULL
);
  localparam logic [2:0] PI_REG_DATA_LO = 3'd0;
  localparam logic [2:0] PI_REG_DATA_HI = 3'd1;
  localparam logic [2:0] PI_REG_ADDR_LO = 3'd2;
  localparam logic [2:0] PI_REG_ADDR_HI = 3'd3;
  localparam logic [2:0] PI_REG_STATUS  = 3'd4;
  localparam int ENTRY_W = 62;
  localparam int READ_BIT = 58;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_ZERO  = (PTR_W+1)'(0);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W+1:0] PEND_ONE  = (PTR_W+2)'(1);
  localparam logic [PTR_W+1:0] PEND_ZERO = (PTR_W+2)'(0);

  logic               wr_a_r, wr_b_r, wr_edge_s;
  logic [31:0]        stage_data_r, rd_data_r;
  logic [15:0]        stage_addr_r;
  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [ENTRY_W-1:0] head_r, head_next_s, new_entry_s;
  logic [PTR_W-1:0]   rd_ptr_r, wr_ptr_r, rd_ptr_next_s;
  logic [PTR_W:0]     count_r, count_next_s;
  logic [PTR_W+1:0]   pend_reads_r, pend_next_s;
  logic               req_valid_r, full_r, busy_r, overflow_r;
  logic               inflight_r, inflight_read_r, inflight_next_s, inflight_read_next_s;
  logic               commit_s, push_s, pop_s, drop_s, done_s, done_read_s, read_push_s;
  logic [3:0]         level_s;

  // Next-state control for the FIFO, the in-flight tracker and the pending-read counter.
  always_comb begin
    wr_edge_s   = wr_b_r & ~wr_a_r;
    commit_s    = wr_edge_s && (PI_A == PI_REG_ADDR_HI);
    pop_s       = req_valid_r & REQ_READY;
    push_s      = commit_s && ((count_r != CNT_FULL) || pop_s);
    drop_s      = commit_s && !push_s;
    done_s      = DONE_STROBE & inflight_r;
    done_read_s = done_s & inflight_read_r;
    read_push_s = push_s & PI_DATA_IN[10];
    new_entry_s = {PI_DATA_IN[13:8], PI_DATA_IN[7:0], stage_addr_r, stage_data_r};
    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
    // The new head bypasses storage when it lands exactly at the next read slot.
    if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
      head_next_s = new_entry_s;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
    if (pop_s) begin
      inflight_next_s      = 1'b1;
      inflight_read_next_s = head_r[READ_BIT];
    end else if (done_s) begin
      inflight_next_s      = 1'b0;
      inflight_read_next_s = inflight_read_r;
    end else begin
      inflight_next_s      = inflight_r;
      inflight_read_next_s = inflight_read_r;
    end
    case ({read_push_s, done_read_s})
      2'b10:   pend_next_s = pend_reads_r + PEND_ONE;
      2'b01:   pend_next_s = pend_reads_r - PEND_ONE;
      default: pend_next_s = pend_reads_r;
    endcase
  end

  // Pi write strobe synchroniser, staging registers and sticky overflow.
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      wr_a_r       <= 1'b1;
      wr_b_r       <= 1'b1;
      stage_data_r <= 32'h0000_0000;
      stage_addr_r <= 16'h0000;
      overflow_r   <= 1'b0;
    end else begin
      wr_a_r <= PI_WR;
      wr_b_r <= wr_a_r;
      if (wr_edge_s) begin
        case (PI_A)
          PI_REG_DATA_LO: stage_data_r[15:0]  <= PI_DATA_IN;
          PI_REG_DATA_HI: stage_data_r[31:16] <= PI_DATA_IN;
          PI_REG_ADDR_LO: stage_addr_r        <= PI_DATA_IN;
          PI_REG_STATUS:  overflow_r          <= 1'b0;
          default:        stage_addr_r        <= stage_addr_r;
        endcase
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Entry storage; slots are only read after being written, so they carry no reset.
  always_ff @(posedge SYSCLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= new_entry_s;
    end
  end

  // FIFO pointers, occupancy and the registered head/flag outputs.
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= CNT_ZERO;
      req_valid_r <= 1'b0;
      head_r      <= {ENTRY_W{1'b0}};
      full_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r    <= rd_ptr_next_s;
      count_r     <= count_next_s;
      req_valid_r <= (count_next_s != CNT_ZERO);
      head_r      <= head_next_s;
      full_r      <= (count_next_s == CNT_FULL);
      busy_r      <= (count_next_s != CNT_ZERO) | inflight_next_s;
    end
  end

  // In-flight request tracking and returned read data.
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      inflight_r      <= 1'b0;
      inflight_read_r <= 1'b0;
      pend_reads_r    <= PEND_ZERO;
      rd_data_r       <= 32'h0000_0000;
    end else begin
      inflight_r      <= inflight_next_s;
      inflight_read_r <= inflight_read_next_s;
      pend_reads_r    <= pend_next_s;
      if (done_read_s) begin
        rd_data_r <= DONE_DATA;
      end
    end
  end

`ifdef PI_QUEUE_LEVEL_STATUS_EN
  // Occupancy for the status word, saturated to its 4-bit field.
  always_comb begin
    if (32'(count_r) > 32'd15) begin
      level_s = 4'd15;
    end else begin
      level_s = 4'(count_r);
    end
  end
`else
  assign level_s = 4'd0;
`endif

  // Pi read mux, decoded straight from the raw address pins.
  always_comb begin
    PI_DATA_OUT = 16'h0000;
    case (PI_A)
      PI_REG_DATA_LO: PI_DATA_OUT = rd_data_r[15:0];
      PI_REG_DATA_HI: PI_DATA_OUT = rd_data_r[31:16];
      PI_REG_ADDR_LO: PI_DATA_OUT = stage_addr_r;
      PI_REG_STATUS:  PI_DATA_OUT = {level_s, 7'd0, overflow_r, busy_r,
                                     (pend_reads_r != PEND_ZERO), (count_r == CNT_ZERO), full_r};
      default:        PI_DATA_OUT = 16'h0000;
    endcase
  end

  assign PI_DATA_OE = ~PI_RD & PI_WR;
  assign REQ_VALID  = req_valid_r;
  assign {REQ_FC, REQ_READ, REQ_SIZE, REQ_ADDR, REQ_DATA} = head_r;
  assign BUSY       = busy_r;
  assign FULL       = full_r;

endmodule

// File: tb/tb_pi_request_queue.sv
// Self-checking bench for pi_request_queue: per-feature tasks plus a scoreboard of committed
// requests that is checked against every head the DUT hands over on REQ_VALID & REQ_READY.
module tb_pi_request_queue;
  localparam int DEPTH = 4;
  localparam logic [2:0] REG_DATA_LO = 3'd0;
  localparam logic [2:0] REG_DATA_HI = 3'd1;
  localparam logic [2:0] REG_ADDR_LO = 3'd2;
  localparam logic [2:0] REG_ADDR_HI = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;
`ifdef PI_QUEUE_LEVEL_STATUS_EN
  localparam bit LVL_EN = 1'b1;
`else
  localparam bit LVL_EN = 1'b0;
`endif

  logic        SYSCLK = 1'b0, RESET = 1'b1, PI_WR = 1'b1, PI_RD = 1'b0;
  logic [2:0]  PI_A = 3'd0;
  logic [15:0] PI_DATA_IN = 16'h0000, PI_DATA_OUT;
  logic        PI_DATA_OE, REQ_VALID, REQ_READY = 1'b0;
  logic [23:0] REQ_ADDR;
  logic [2:0]  REQ_FC;
  logic [1:0]  REQ_SIZE;
  logic        REQ_READ;
  logic [31:0] REQ_DATA;
  logic        DONE_STROBE = 1'b0;
  logic [31:0] DONE_DATA = 32'h0;
  logic        BUSY, FULL;

  int checks = 0, errors = 0, pops_seen = 0, dropped = 0;
  logic [61:0] exp_q[$];
  logic [31:0] m_stage_data = 32'h0;
  logic [15:0] m_stage_addr = 16'h0;
  logic [15:0] rd;

  pi_request_queue #(.DEPTH(DEPTH)) dut (
    .SYSCLK(SYSCLK), .RESET(RESET), .PI_WR(PI_WR), .PI_RD(PI_RD), .PI_A(PI_A),
    .PI_DATA_IN(PI_DATA_IN), .PI_DATA_OUT(PI_DATA_OUT), .PI_DATA_OE(PI_DATA_OE),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR), .REQ_FC(REQ_FC),
    .REQ_SIZE(REQ_SIZE), .REQ_READ(REQ_READ), .REQ_DATA(REQ_DATA),
    .DONE_STROBE(DONE_STROBE), .DONE_DATA(DONE_DATA), .BUSY(BUSY), .FULL(FULL)
  );

  always #5 SYSCLK = ~SYSCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard: a handshake seen at the negedge completes on the following posedge.
  always @(negedge SYSCLK) begin : monitor
    logic [61:0] e;
    if (RESET === 1'b0 && REQ_VALID === 1'b1 && REQ_READY === 1'b1) begin
      pops_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got addr %h with empty scoreboard", REQ_ADDR);
      end else begin
        e = exp_q.pop_front();
        if ({REQ_FC, REQ_READ, REQ_SIZE, REQ_ADDR, REQ_DATA} !== e) begin
          errors++;
          $display("FAIL pop_entry: got %h expected %h",
                   {REQ_FC, REQ_READ, REQ_SIZE, REQ_ADDR, REQ_DATA}, e);
        end
      end
    end
  end

  function automatic logic [15:0] lvl(input int n);
    return LVL_EN ? (16'(n) << 12) : 16'h0000;
  endfunction

  task automatic pi_write(input logic [2:0] a, input logic [15:0] d, input bit pop_with);
    @(posedge SYSCLK); #1;
    PI_A = a; PI_DATA_IN = d; PI_WR = 1'b0;
    @(posedge SYSCLK); #1;
    if (pop_with) REQ_READY = 1'b1;
    @(negedge SYSCLK);
    case (a)
      REG_DATA_LO: m_stage_data[15:0]  = d;
      REG_DATA_HI: m_stage_data[31:16] = d;
      REG_ADDR_LO: m_stage_addr        = d;
      REG_ADDR_HI: begin
        if (exp_q.size() >= DEPTH && !(REQ_VALID === 1'b1 && REQ_READY === 1'b1)) dropped++;
        else exp_q.push_back({d[13:11], d[10], d[9:8], d[7:0], m_stage_addr, m_stage_data});
      end
      default: ;
    endcase
    @(posedge SYSCLK); #1;
    PI_WR = 1'b1;
    if (pop_with) REQ_READY = 1'b0;
  endtask

  task automatic pi_read(input logic [2:0] a, output logic [15:0] d);
    PI_A = a; PI_RD = 1'b1; #1;
    d = PI_DATA_OUT; PI_RD = 1'b0;
  endtask

  task automatic done_pulse(input logic [31:0] dd);
    @(posedge SYSCLK); #1; DONE_STROBE = 1'b1; DONE_DATA = dd;
    @(posedge SYSCLK); #1; DONE_STROBE = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    @(posedge SYSCLK); #1; REQ_READY = 1'b1;
    while (REQ_VALID === 1'b1 && n < max_cycles) begin
      @(posedge SYSCLK); #1; n++;
    end
    REQ_READY = 1'b0;
    checks++; if (REQ_VALID !== 1'b0) begin errors++; $display("FAIL drain_timeout: REQ_VALID got %b expected 0", REQ_VALID); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drain_left: got %0d entries expected 0", exp_q.size()); end
  endtask

  task automatic commit_write(input logic [15:0] alo, input logic [7:0] ahi, input bit pop_with);
    pi_write(REG_DATA_LO, alo ^ 16'h5A5A, 1'b0);
    pi_write(REG_ADDR_LO, alo, 1'b0);
    pi_write(REG_ADDR_HI, {8'h01, ahi}, pop_with);
  endtask

  task automatic test_reset();
    @(posedge SYSCLK); @(posedge SYSCLK); #1; RESET = 1'b0;
    @(posedge SYSCLK); #1;
    checks++; if (REQ_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", REQ_VALID); end
    checks++; if (BUSY !== 1'b0 || FULL !== 1'b0) begin errors++; $display("FAIL reset_busy_full: got %b%b expected 00", BUSY, FULL); end
    pi_read(REG_STATUS, rd);
    checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL reset_status: got %h expected 0002", rd); end
    pi_read(REG_DATA_LO, rd);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL reset_rd_data: got %h expected 0000", rd); end
    PI_RD = 1'b0; #1;
    checks++; if (PI_DATA_OE !== 1'b1) begin errors++; $display("FAIL oe_idle: got %b expected 1", PI_DATA_OE); end
    PI_RD = 1'b1; #1;
    checks++; if (PI_DATA_OE !== 1'b0) begin errors++; $display("FAIL oe_read: got %b expected 0", PI_DATA_OE); end
    PI_RD = 1'b0;
  endtask

  task automatic test_read_request();
    pi_write(REG_DATA_LO, 16'h5678, 1'b0);
    pi_write(REG_DATA_HI, 16'h1234, 1'b0);
    pi_write(REG_ADDR_LO, 16'hBEEF, 1'b0);
    pi_read(REG_ADDR_LO, rd);
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL stage_addr_read: got %h expected BEEF", rd); end
    checks++; if (REQ_VALID !== 1'b0) begin errors++; $display("FAIL pre_commit_valid: got %b expected 0", REQ_VALID); end
    pi_write(REG_ADDR_HI, 16'h0612, 1'b0);
    checks++; if (REQ_VALID !== 1'b1) begin errors++; $display("FAIL commit_valid: got %b expected 1", REQ_VALID); end
    checks++; if (REQ_ADDR !== 24'h12BEEF || REQ_DATA !== 32'h12345678) begin errors++; $display("FAIL commit_addr_data: got %h %h expected 12beef 12345678", REQ_ADDR, REQ_DATA); end
    checks++; if (REQ_FC !== 3'd0 || REQ_READ !== 1'b1 || REQ_SIZE !== 2'd2) begin errors++; $display("FAIL commit_fields: got fc %0d rd %b sz %0d expected 0 1 2", REQ_FC, REQ_READ, REQ_SIZE); end
    pi_read(REG_STATUS, rd);
    checks++; if (rd !== (lvl(1) | 16'h000C)) begin errors++; $display("FAIL commit_status: got %h expected %h", rd, lvl(1) | 16'h000C); end
    @(posedge SYSCLK); #1; REQ_READY = 1'b1;
    @(posedge SYSCLK); #1; REQ_READY = 1'b0;
    checks++; if (REQ_VALID !== 1'b0 || BUSY !== 1'b1) begin errors++; $display("FAIL inflight_busy: got valid %b busy %b expected 0 1", REQ_VALID, BUSY); end
    done_pulse(32'hCAFEF00D);
    pi_read(REG_DATA_LO, rd);
    checks++; if (rd !== 16'hF00D) begin errors++; $display("FAIL done_data_lo: got %h expected F00D", rd); end
    pi_read(REG_DATA_HI, rd);
    checks++; if (rd !== 16'hCAFE) begin errors++; $display("FAIL done_data_hi: got %h expected CAFE", rd); end
    pi_read(REG_STATUS, rd);
    checks++; if (rd !== 16'h0002 || BUSY !== 1'b0) begin errors++; $display("FAIL done_status: got %h busy %b expected 0002 0", rd, BUSY); end
  endtask

  task automatic test_overflow();
    dropped = 0;
    for (int i = 0; i < 5; i++) commit_write(16'h2000 + 16'(i), 8'(8'h40 + i), 1'b0);
    checks++; if (FULL !== 1'b1 || dropped != 1) begin errors++; $display("FAIL overflow_full: got full %b drops %0d expected 1 1", FULL, dropped); end
    pi_read(REG_STATUS, rd);
    checks++; if (rd !== (lvl(4) | 16'h0019)) begin errors++; $display("FAIL overflow_status: got %h expected %h", rd, lvl(4) | 16'h0019); end
    pi_write(REG_STATUS, 16'h0000, 1'b0);
    pi_read(REG_STATUS, rd);
    checks++; if (rd !== (lvl(4) | 16'h0009)) begin errors++; $display("FAIL overflow_clear: got %h expected %h", rd, lvl(4) | 16'h0009); end
    pops_seen = 0;
    drain(20);
    checks++; if (pops_seen != 4) begin errors++; $display("FAIL overflow_drain_count: got %0d expected 4", pops_seen); end
    checks++; if (FULL !== 1'b0 || BUSY !== 1'b1) begin errors++; $display("FAIL drained_flags: got full %b busy %b expected 0 1", FULL, BUSY); end
    done_pulse(32'h0BAD0BAD);
    pi_read(REG_DATA_LO, rd);
    checks++; if (rd !== 16'hF00D || BUSY !== 1'b0) begin errors++; $display("FAIL write_done_keeps_data: got %h busy %b expected F00D 0", rd, BUSY); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) commit_write(16'h3000 + 16'(i), 8'(8'h60 + i), 1'b0);
    pops_seen = 0;
    commit_write(16'h3004, 8'h64, 1'b1);
    checks++; if (FULL !== 1'b1 || pops_seen != 1) begin errors++; $display("FAIL pushpop_full: got full %b pops %0d expected 1 1", FULL, pops_seen); end
    pi_read(REG_STATUS, rd);
    checks++; if (rd !== (lvl(4) | 16'h0009)) begin errors++; $display("FAIL pushpop_status: got %h expected %h", rd, lvl(4) | 16'h0009); end
    drain(20);
    checks++; if (pops_seen != 5) begin errors++; $display("FAIL pushpop_drain_count: got %0d expected 5", pops_seen); end
    done_pulse(32'h0);
  endtask

  task automatic test_level();
    for (int i = 0; i < 3; i++) commit_write(16'h4000 + 16'(i), 8'(8'h70 + i), 1'b0);
    pi_read(REG_STATUS, rd);
    checks++; if (rd !== (lvl(3) | 16'h0008)) begin errors++; $display("FAIL level_status: got %h expected %h", rd, lvl(3) | 16'h0008); end
    drain(20);
    done_pulse(32'h0);
  endtask

  task automatic test_pop_done_reset();
    pi_write(REG_ADDR_LO, 16'h0100, 1'b0);
    pi_write(REG_ADDR_HI, 16'h0420, 1'b0);
    pi_write(REG_ADDR_HI, 16'h0521, 1'b0);
    @(posedge SYSCLK); #1; REQ_READY = 1'b1;
    @(posedge SYSCLK); #1; REQ_READY = 1'b1; DONE_STROBE = 1'b1; DONE_DATA = 32'hA5A55A5A;
    @(posedge SYSCLK); #1; REQ_READY = 1'b0; DONE_STROBE = 1'b0;
    pi_read(REG_DATA_LO, rd);
    checks++; if (rd !== 16'h5A5A) begin errors++; $display("FAIL popdone_lo: got %h expected 5A5A", rd); end
    pi_read(REG_DATA_HI, rd);
    checks++; if (rd !== 16'hA5A5) begin errors++; $display("FAIL popdone_hi: got %h expected A5A5", rd); end
    pi_read(REG_STATUS, rd);
    checks++; if (rd !== 16'h000E || REQ_VALID !== 1'b0) begin errors++; $display("FAIL popdone_status: got %h valid %b expected 000e 0", rd, REQ_VALID); end
    RESET = 1'b1; #1;
    checks++; if (BUSY !== 1'b0 || REQ_VALID !== 1'b0) begin errors++; $display("FAIL async_reset: got busy %b valid %b expected 0 0", BUSY, REQ_VALID); end
    exp_q.delete(); m_stage_data = 32'h0; m_stage_addr = 16'h0;
    @(posedge SYSCLK); #1; RESET = 1'b0;
    pi_read(REG_STATUS, rd);
    checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL post_reset_status: got %h expected 0002", rd); end
    done_pulse(32'h11112222);
    pi_read(REG_DATA_LO, rd);
    checks++; if (rd !== 16'h0000 || BUSY !== 1'b0) begin errors++; $display("FAIL late_done_ignored: got %h busy %b expected 0000 0", rd, BUSY); end
    pi_read(REG_STATUS, rd);
    checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL late_done_status: got %h expected 0002", rd); end
  endtask

  initial begin
    test_reset();
    test_read_request();
    test_overflow();
    test_full_push_pop();
    test_level();
    test_pop_done_reset();
    repeat (2) @(posedge SYSCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
